// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter output stages.
//   FIR_DW / FIR_ODW : filter output width and stage output width (signed Q1.x)
//   dw_t / odw_t     : signed sample types at those widths
//   round_sat()      : half-up round then clamp a dw_t sample into odw_t
package fir_pkg;

    localparam int FIR_DW  = 10;
    localparam int FIR_ODW = 8;

    typedef logic signed [FIR_DW-1:0]  dw_t;
    typedef logic signed [FIR_ODW-1:0] odw_t;

    localparam int SH = FIR_DW - FIR_ODW;

    // One extra bit of headroom so the rounding add can never wrap.
    typedef logic signed [FIR_DW:0] ext_t;

    localparam ext_t RND  = ext_t'(1) <<< (SH - 1);
    localparam ext_t MAXV = (ext_t'(1) <<< (FIR_ODW - 1)) - ext_t'(1);
    localparam ext_t MINV = -(ext_t'(1) <<< (FIR_ODW - 1));

    // Adding half an output LSB before the arithmetic shift gives half-up
    // rounding: ties always move toward +inf.
    function automatic odw_t round_sat(dw_t x);
        ext_t t;
        t = ext_t'(x) + RND;
        t = t >>> SH;
        if (t > MAXV)
            t = MAXV;
        else if (t < MINV)
            t = MINV;
        return odw_t'(t[FIR_ODW-1:0]);
    endfunction

endpackage

// File: rtl/fir_decim_out_fifo.sv
// sync_fifo: small synchronous FIFO with a registered head.
//   clk, rst_n      : clock, synchronous active-low reset
//   push, wdata     : write strobe and data (caller never pushes when full
//                     unless it also pops)
//   pop             : consume head (caller only pops when non-empty)
//   rdata           : registered head; holds its last value once drained
//   full, empty     : occupancy flags
//   level           : occupancy 0..DEPTH
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem;
    logic [PW-1:0]               wr_ptr;
    logic [PW-1:0]               rd_ptr;
    logic [PW-1:0]               rd_nxt;

    assign full   = (level == LW'(DEPTH));
    assign empty  = (level == '0);
    assign rd_nxt = pop ? rd_ptr + PW'(1) : rd_ptr;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            rdata  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_nxt;
            if (push && !pop)
                level <= level + LW'(1);
            else if (pop && !push)
                level <= level - LW'(1);
            // The head register always tracks the entry at the post-op read
            // pointer. If that slot is the one being written this cycle, the
            // memory is not yet updated, so take the incoming data directly.
            if (push && rd_nxt == wr_ptr)
                rdata <= wdata;
            else if (pop && level > LW'(1))
                rdata <= mem[rd_nxt];
        end
    end

endmodule

// File: rtl/fir_decim_out.sv
// fir_decim_out: decimating output stage behind the FIR filter.
// Keeps one strobed sample in every DECIM (the one at index PHASE), rounds
// and saturates it to ODW bits, and buffers it for a valid/ready consumer.
//   clk, rst_n         : clock, synchronous active-low reset
//   in_vld, in_data    : filter output strobe and signed sample
//   out_vld, out_rdy   : FIFO non-empty / consumer accept
//   out_data           : head-of-FIFO sample, signed
//   level              : FIFO occupancy 0..DEPTH
//   ovf, clr_ovf       : sticky "kept sample dropped" flag and its clear
module fir_decim_out
    import fir_pkg::*;
#(
    parameter int DW    = FIR_DW,
    parameter int ODW   = FIR_ODW,
    parameter int DECIM = 4,
    parameter int PHASE = 0,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_vld,
    input  logic [DW-1:0]          in_data,
    output logic                   out_vld,
    input  logic                   out_rdy,
    output logic [ODW-1:0]         out_data,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    input  logic                   clr_ovf
);
    // The rounding helper is shared with other stages at the package widths.
    if (DW != FIR_DW || ODW != FIR_ODW) begin : g_width_chk
        $error("fir_decim_out: DW/ODW must match fir_pkg widths");
    end
    if (DECIM < 1 || PHASE < 0 || PHASE >= DECIM) begin : g_phase_chk
        $error("fir_decim_out: PHASE must lie in 0..DECIM-1");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_chk
        $error("fir_decim_out: DEPTH must be a power of two >= 2");
    end

    // A one-bit counter that never leaves 0 covers DECIM=1.
    localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CW-1:0] LAST = CW'(DECIM - 1);
    localparam logic [CW-1:0] PH   = CW'(PHASE);

    logic [CW-1:0] cnt;
    logic          keep;
    logic          pop;
    logic          push;
    logic          drop;
    logic          full;
    logic          empty;
    odw_t          rs;

    assign keep    = in_vld && (cnt == PH);
    assign pop     = out_vld && out_rdy;
    assign push    = keep && (!full || pop);
    assign drop    = keep && full && !pop;
    assign rs      = round_sat(dw_t'(in_data));
    assign out_vld = !empty;

    always_ff @(posedge clk) begin
        if (!rst_n)
            cnt <= '0;
        else if (in_vld)
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    // A drop in the same cycle as a clear wins, so no drop goes unreported.
    always_ff @(posedge clk) begin
        if (!rst_n)
            ovf <= 1'b0;
        else if (drop)
            ovf <= 1'b1;
        else if (clr_ovf)
            ovf <= 1'b0;
    end

    sync_fifo #(
        .WIDTH (ODW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (rs),
        .pop   (pop),
        .rdata (out_data),
        .full  (full),
        .empty (empty),
        .level (level)
    );

endmodule

// File: doc/fir_decim_out.md
Name: fir_decim_out

Overview:
- Output stage directly downstream of the FIR filter.
- Takes the filter's Q1.(DW-1) output on a sample strobe and keeps one sample in every DECIM.
- Rounds and saturates each kept sample to Q1.(ODW-1), then buffers it in a small FIFO.
- Presents the buffered samples on a valid/ready interface to the next consumer (DMA, serializer, next filter). Decouples the free-running filter from a consumer that may stall.

Parameters:
- DW, 10: input sample width, signed Q1.(DW-1); matches filter output width.
- ODW, 8: output sample width, signed Q1.(ODW-1); must satisfy 2 <= ODW < DW.
- DECIM, 4: decimation ratio, >= 1; DECIM=1 keeps every sample.
- PHASE, 0: which sample index in 0..DECIM-1 is kept.
- DEPTH, 4: FIFO depth in entries; power of two, >= 2.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: synchronous reset, active-low; clock is clk.
- in_vld, input, 1: strobe, one cycle per new filter output. Integrator ties it to the filter's en delayed one cycle.
- in_data, input, DW: filter output sample, signed.
- out_vld, output, 1: FIFO non-empty.
- out_rdy, input, 1: consumer accepts out_data this cycle when out_vld=1.
- out_data, output, ODW: head-of-FIFO sample, signed.
- level, output, $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- ovf, output, 1: sticky flag; a kept sample was dropped.
- clr_ovf, input, 1: clears ovf.

Behaviour:
- Reset (rst_n=0 at posedge), values after the edge:
  - phase counter=0, FIFO empty, level=0.
  - out_vld=0, out_data=0, ovf=0.
  - Reset mid-operation discards all buffered samples with no partial output.
- Phase counter:
  - Range 0..DECIM-1; increments on each in_vld and wraps from DECIM-1 to 0. Holds when in_vld=0.
  - "keep" = in_vld && (count==PHASE), evaluated before the increment.
- Round/saturate is combinational on in_data:
  - Computed at DW+1 bits: tmp = in_data + 2^(DW-ODW-1), arithmetic shift right by (DW-ODW).
  - Clamp to [-2^(ODW-1), 2^(ODW-1)-1].
  - Rounding is half-up (toward +inf on ties).
- Push rule: push = keep && (!full || pop), where pop = out_vld && out_rdy.
  - When full, a simultaneous pop frees the slot and the push succeeds.
- Drop rule: keep && full && !pop -> sample discarded, ovf set next cycle.
- ovf update:
  - Set has priority over clr_ovf in the same cycle.
  - Otherwise clr_ovf=1 clears it.
  - Otherwise holds.
- Latency: a sample kept at edge t (empty FIFO) shows out_vld=1 and out_data valid after edge t. One register stage; no combinational path in_data -> out_data.
- Push+pop when empty is not possible, because out_vld=0; a push then takes effect next cycle with no bypass.
- out_data:
  - Always equals the head entry while out_vld=1.
  - Holds its last value after the FIFO drains.
  - out_data and out_vld are stable while out_vld && !out_rdy.
- level:
  - +1 on push only, -1 on pop only, unchanged on both or neither.
  - full = (level==DEPTH), empty = (level==0).
- Pointers are $clog2(DEPTH) bits and wrap naturally at DEPTH.

Decomposition:
- Shared package fir_pkg:
  - typedefs dw_t (signed DW) and odw_t (signed ODW).
  - Function round_sat(dw_t) -> odw_t, reused by other output stages.
- Sub-module sync_fifo, parameterized by WIDTH and DEPTH:
  - push/pop/full/empty/level, registered head.
  - Top level holds the phase counter, round_sat, drop/ovf logic and instantiates sync_fifo.

Test Plan:
- Decimation: DECIM=4, PHASE=1, out_rdy=1, in_vld every cycle with in_data=0,4,8,...,60 -> outputs 1,5,9,13 (4,20,36,52 >>2). Exactly one output per 4 strobes; gaps in in_vld do not advance the counter.
- Round/sat (DW=10, ODW=8, DECIM=1):
  - in 5 -> 1; 6 -> 2; -6 -> -1; -7 -> -2.
  - 511 -> 127 (saturated); -512 -> -128; 509 -> 127.
- Backpressure/overflow: DECIM=1, out_rdy=0, 6 strobes with 4..24 step 4 -> level stops at 4, out_data=1 held, ovf=1 after 5th strobe. Then out_rdy=1 -> outputs 1,2,3,4, then out_vld=0.
- Full with simultaneous push/pop: level=4, out_rdy=1 and keep in same cycle -> level stays 4, ovf stays 0, new sample appears after the 3 remaining.
- ovf priority: drop and clr_ovf in same cycle -> ovf=1; next cycle clr_ovf alone -> ovf=0.
- Reset mid-operation: level=3, phase count=2, assert rst_n=0 one cycle -> out_vld=0, level=0, out_data=0. First kept sample afterwards follows PHASE counted from 0.
